// File: rtl/bpm_tracker_if.sv
// Beat input / tempo output bundle between the beat detector and tempo consumers.
interface bpm_tracker_if #(
    parameter int unsigned BPM_W = 8
);
    logic             beat;
    logic [BPM_W-1:0] default_bpm;
    logic [BPM_W-1:0] bpm_out;
    logic             bpm_valid;
    logic             locked;

    // Upstream side: supplies beats and the fallback tempo, consumes results.
    modport master (
        output beat, default_bpm,
        input  bpm_out, bpm_valid, locked
    );

    // Tracker side.
    modport slave (
        input  beat, default_bpm,
        output bpm_out, bpm_valid, locked
    );
endinterface

// File: rtl/bpm_tracker.sv
// Beat-interval tempo tracker: debounced interval measurement, sequential
// divide to BPM, moving average over 2^AVG_LOG2 pushes, timeout fallback.
module bpm_tracker #(
    parameter int unsigned CLK_HZ    = 100000,
    parameter int unsigned BPM_W     = 8,
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned MIN_BPM   = 30,
    parameter int unsigned MAX_BPM   = 255,
    parameter int unsigned START_BPM = 80,
    parameter int unsigned CNT_W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    bpm_tracker_if.slave  bus
);
    localparam int unsigned     DEPTH        = 1 << AVG_LOG2;
    localparam longint unsigned DIVIDEND     = 64'(CLK_HZ) * 64'd60;
    localparam longint unsigned MAX_INTERVAL = DIVIDEND / 64'(MIN_BPM);
    localparam longint unsigned MIN_INTERVAL = DIVIDEND / 64'(MAX_BPM);
    localparam int unsigned     SUM_W        = BPM_W + AVG_LOG2;
    localparam int unsigned     IDX_W        = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned     LOCK_W       = AVG_LOG2 + 1;
    localparam int unsigned     STEP_W       = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    localparam logic [CNT_W-1:0] MIN_IVL  = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0] MAX_IVL  = CNT_W'(MAX_INTERVAL);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIVIDEND);
    localparam logic [CNT_W-1:0] MIN_Q    = CNT_W'(MIN_BPM);
    localparam logic [CNT_W-1:0] MAX_Q    = CNT_W'(MAX_BPM);
    localparam logic [BPM_W-1:0] START_V  = BPM_W'(START_BPM);

    // Parameter sanity: dividend must fit the divider, debounce must cover a full divide.
    generate
        if ((DIVIDEND >= (64'd1 << CNT_W)) || (MIN_INTERVAL <= 64'(CNT_W + 2))) begin : g_param_check
            $error("bpm_tracker: 60*CLK_HZ must fit CNT_W bits and MIN_INTERVAL must exceed CNT_W+2");
        end
    endgenerate

    typedef enum logic [1:0] {S_COUNT, S_DIV, S_UPDATE} state_t;

    state_t             state, state_next;
    logic               prev_beat;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   divisor;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W-1:0]   quo;
    logic [STEP_W-1:0]  step;
    logic [BPM_W-1:0]   dflt_latch;
    logic               timeout_push;
    logic [BPM_W-1:0]   buffer [DEPTH];
    logic [SUM_W-1:0]   sum;
    logic [IDX_W-1:0]   idx;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [BPM_W-1:0]   bpm_out;
    logic               bpm_valid;
    logic               locked;

    logic               edge_c, accept_c, expire_c, div_last_c;
    logic [CNT_W:0]     trial_c;
    logic               fits_c;
    logic [CNT_W-1:0]   rem_next_c;
    logic [CNT_W-1:0]   quo_clamp_c;
    logic [BPM_W-1:0]   push_val_c;
    logic [SUM_W-1:0]   sum_next_c;
    logic [IDX_W-1:0]   idx_next_c;
    logic [LOCK_W-1:0]  lock_next_c;

    // Beat edge qualification; an accepted beat takes priority over a timeout.
    assign edge_c     = bus.beat & ~prev_beat;
    assign accept_c   = (state == S_COUNT) && edge_c && (counter >= MIN_IVL);
    assign expire_c   = (state == S_COUNT) && !accept_c && (counter == MAX_IVL);
    assign div_last_c = (state == S_DIV) && (step == STEP_W'(CNT_W - 1));

    assign bus.bpm_out   = bpm_out;
    assign bus.bpm_valid = bpm_valid;
    assign bus.locked    = locked;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_COUNT;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_COUNT: begin
                if (accept_c)      state_next = S_DIV;
                else if (expire_c) state_next = S_UPDATE;
            end
            S_DIV:    if (div_last_c) state_next = S_UPDATE;
            S_UPDATE: state_next = S_COUNT;
            default:  state_next = S_COUNT;
        endcase
    end

    // Divider step, quotient clamp and averaging datapath values.
    always_comb begin
        trial_c     = {rem, quo[CNT_W-1]};
        fits_c      = (trial_c >= {1'b0, divisor});
        rem_next_c  = fits_c ? CNT_W'(trial_c - {1'b0, divisor}) : CNT_W'(trial_c);
        quo_clamp_c = quo;
        if (quo < MIN_Q)      quo_clamp_c = MIN_Q;
        else if (quo > MAX_Q) quo_clamp_c = MAX_Q;
        push_val_c  = timeout_push ? dflt_latch : BPM_W'(quo_clamp_c);
        sum_next_c  = sum + SUM_W'(push_val_c) - SUM_W'(buffer[idx]);
        idx_next_c  = (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
        if (timeout_push)                    lock_next_c = '0;
        else if (lock_cnt == LOCK_W'(DEPTH)) lock_next_c = lock_cnt;
        else                                 lock_next_c = lock_cnt + LOCK_W'(1);
    end

    // Free-running interval counter, restarted by an accepted beat or a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            prev_beat <= 1'b0;
        end else begin
            prev_beat <= bus.beat;
            if (accept_c || expire_c) counter <= '0;
            else                      counter <= counter + CNT_W'(1);
        end
    end

    // Restoring divider and push-source capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor      <= '0;
            rem          <= '0;
            quo          <= '0;
            step         <= '0;
            dflt_latch   <= '0;
            timeout_push <= 1'b0;
        end else if (accept_c) begin
            divisor      <= counter;
            rem          <= '0;
            quo          <= DIV_INIT;
            step         <= '0;
            timeout_push <= 1'b0;
        end else if (expire_c) begin
            dflt_latch   <= bus.default_bpm;
            timeout_push <= 1'b1;
        end else if (state == S_DIV) begin
            rem  <= rem_next_c;
            quo  <= {quo[CNT_W-2:0], fits_c};
            step <= step + STEP_W'(1);
        end
    end

    // Moving-average buffer, lock tracking and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) buffer[i] <= START_V;
            sum       <= SUM_W'(START_BPM) << AVG_LOG2;
            idx       <= '0;
            lock_cnt  <= '0;
            bpm_out   <= START_V;
            bpm_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            bpm_valid <= (state == S_UPDATE);
            if (state == S_UPDATE) begin
                sum         <= sum_next_c;
                buffer[idx] <= push_val_c;
                idx         <= idx_next_c;
                lock_cnt    <= lock_next_c;
                locked      <= (lock_next_c == LOCK_W'(DEPTH));
                bpm_out     <= BPM_W'(sum_next_c >> AVG_LOG2);
            end
        end
    end
endmodule

// File: tb/tb_bpm_tracker.sv
// Self-checking bench for bpm_tracker, scaled clock so timeouts stay short.
module tb_bpm_tracker;
    localparam int CLK_HZ    = 1000;
    localparam int CNT_W     = 16;
    localparam int BPM_W     = 8;
    localparam int AVG_LOG2  = 2;
    localparam int DEPTH     = 4;
    localparam int MIN_BPM   = 30;
    localparam int MAX_BPM   = 255;
    localparam int START_BPM = 80;
    localparam int DIVIDEND  = 60 * CLK_HZ;
    localparam int MIN_IVL   = DIVIDEND / MAX_BPM;   // 235
    localparam int MAX_IVL   = DIVIDEND / MIN_BPM;   // 2000
    localparam int LATENCY   = CNT_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bpm_tracker_if #(.BPM_W(BPM_W)) bus ();

    bpm_tracker #(
        .CLK_HZ(CLK_HZ), .BPM_W(BPM_W), .AVG_LOG2(AVG_LOG2), .MIN_BPM(MIN_BPM),
        .MAX_BPM(MAX_BPM), .START_BPM(START_BPM), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ref_cyc = 0;
    int stray = 0;
    int hist[$];
    bit meas[$];
    int exp_bpm;
    bit exp_lock;

    // Reference model: tempo of one interval, and average / lock over the last DEPTH pushes.
    function automatic int bpm_of(input int ivl);
        int q;
        q = DIVIDEND / ivl;
        if (q < MIN_BPM) q = MIN_BPM;
        if (q > MAX_BPM) q = MAX_BPM;
        return q % (1 << BPM_W);
    endfunction

    task automatic model_reset();
        hist.delete();
        meas.delete();
        for (int i = 0; i < DEPTH; i++) begin
            hist.push_back(START_BPM);
            meas.push_back(1'b0);
        end
        exp_bpm  = START_BPM;
        exp_lock = 1'b0;
    endtask

    task automatic model_push(input int v, input bit m);
        int s;
        hist.push_back(v);
        void'(hist.pop_front());
        meas.push_back(m);
        void'(meas.pop_front());
        s = 0;
        exp_lock = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s += hist[i];
            if (!meas[i]) exp_lock = 1'b0;
        end
        exp_bpm = s / DEPTH;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance to a cycle index, counting any update strobe seen on the way.
    task automatic idle_until(input int target);
        while (cyc < target) begin
            tick();
            if (bus.bpm_valid === 1'b1) stray++;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.beat = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        ref_cyc = cyc;
        stray = 0;
        model_reset();
    endtask

    // Wait (bounded) for the next update strobe and compare against the model.
    task automatic observe_update(input int due, input string name);
        int n;
        n = 0;
        while (bus.bpm_valid !== 1'b1 && n < LATENCY + 8) begin
            tick();
            n++;
        end
        checks++;
        if (bus.bpm_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: no bpm_valid by cycle %0d, expected at %0d", name, cyc, due);
        end else begin
            checks++;
            if (cyc !== due) begin
                errors++;
                $display("FAIL %s latency: bpm_valid at cycle %0d, expected %0d", name, cyc, due);
            end
            checks++;
            if (bus.bpm_out !== BPM_W'(exp_bpm)) begin
                errors++;
                $display("FAIL %s bpm_out: got %0d expected %0d", name, bus.bpm_out, exp_bpm);
            end
            checks++;
            if (bus.locked !== exp_lock) begin
                errors++;
                $display("FAIL %s locked: got %0b expected %0b", name, bus.locked, exp_lock);
            end
            tick();
            checks++;
            if (bus.bpm_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s strobe width: bpm_valid=%0b expected 0", name, bus.bpm_valid);
            end
        end
    endtask

    task automatic check_no_stray(input string name);
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL %s stray strobes: got %0d expected 0", name, stray);
        end
        stray = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.bpm_out !== BPM_W'(START_BPM) || bus.bpm_valid !== 1'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL %s: bpm_out=%0d valid=%0b locked=%0b expected %0d/0/0",
                     name, bus.bpm_out, bus.bpm_valid, bus.locked, START_BPM);
        end
    endtask

    // Beat whose rising edge samples the interval counter at value ivl.
    task automatic measured_beat(input int ivl, input string name);
        int e0;
        idle_until(ref_cyc + ivl);
        bus.beat = 1'b1;
        tick();
        if (bus.bpm_valid === 1'b1) stray++;
        bus.beat = 1'b0;
        e0 = cyc;
        ref_cyc = cyc;
        model_push(bpm_of(ivl), 1'b1);
        observe_update(e0 + LATENCY, name);
        check_no_stray(name);
    endtask

    // Short pulse that must be rejected by the debounce window.
    task automatic glitch(input int ivl);
        idle_until(ref_cyc + ivl);
        bus.beat = 1'b1;
        tick();
        if (bus.bpm_valid === 1'b1) stray++;
        bus.beat = 1'b0;
    endtask

    task automatic timeout_push(input string name);
        int t0;
        t0 = ref_cyc + MAX_IVL + 1;
        idle_until(t0);
        ref_cyc = t0;
        model_push(int'(bus.default_bpm), 1'b0);
        observe_update(t0 + 1, name);
        check_no_stray(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.beat = 1'b0;
        bus.default_bpm = 8'd100;
        tick();
        tick();
        check_reset_outputs("reset_held");
        rst = 1'b0;
        ref_cyc = cyc;
        model_reset();
        tick();
        check_reset_outputs("reset_released");
        stray = 0;
    endtask

    task automatic test_steady();
        for (int i = 0; i < DEPTH; i++) measured_beat(500, $sformatf("steady_%0d", i));
        checks++;
        if (bus.bpm_out !== 8'd120 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL steady_final: bpm_out=%0d locked=%0b expected 120/1", bus.bpm_out, bus.locked);
        end
    endtask

    task automatic test_debounce();
        glitch(100);
        measured_beat(500, "debounce_after_glitch");
        measured_beat(MIN_IVL, "min_interval_255");
        glitch(MIN_IVL - 1);
        measured_beat(240, "interval_240");
    endtask

    task automatic test_mid_stream_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_stream_reset");
        tick();
        apply_reset();
    endtask

    task automatic test_mid_divide_reset();
        idle_until(ref_cyc + 500);
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_divide_reset");
        tick();
        rst = 1'b0;
        ref_cyc = cyc;
        stray = 0;
        model_reset();
        idle_until(cyc + 2 * LATENCY);
        check_no_stray("aborted_divide");
        measured_beat(500, "after_abort");
    endtask

    task automatic test_timeout();
        apply_reset();
        bus.default_bpm = 8'd100;
        for (int i = 0; i < DEPTH; i++) timeout_push($sformatf("timeout_%0d", i));
    endtask

    task automatic test_lock_loss();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) measured_beat(500, $sformatf("lock_%0d", i));
        bus.default_bpm = 8'd60;
        timeout_push("lock_loss");
    endtask

    task automatic test_random();
        int r;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                bus.default_bpm = BPM_W'($urandom_range(0, 255));
                timeout_push($sformatf("rand_timeout_%0d", i));
            end else begin
                if (r == 1) glitch(int'($urandom_range(20, MIN_IVL - 2)));
                measured_beat(int'($urandom_range(MIN_IVL, MAX_IVL)), $sformatf("rand_beat_%0d", i));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.beat = 1'b0;
        bus.default_bpm = '0;
        test_reset();
        test_steady();
        test_debounce();
        test_mid_stream_reset();
        test_mid_divide_reset();
        test_timeout();
        test_lock_loss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
